// File: rtl/mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_stage
// Purpose  : MEM stage of a 5-stage datapath. Performs data-memory load/store
//            against an internal word RAM with a fixed access latency, resolves
//            branch/jump redirect, and drives the MEM/WB pipeline register.
//            Upstream stages are stalled while an access is in flight.
// Ports    : clk, rst (async, active-high)
//            EX/MEM inputs : jumpI, branchI, memReadI, memWriteI, memtoRegI,
//                            regWriteI, siguienteInstruccionI[31:0], zfI,
//                            aluResultI[31:0], readData2I[31:0],
//                            writeRegistrerI[4:0]
//            Control out   : stallO, pcSrcO, targetO[31:0]
//            MEM/WB out    : regWriteO, memtoRegO, readDataO[31:0],
//                            aluResultO[31:0], writeRegistrerO[4:0], validO
//            Trap out      : misalignO
// Config   : MEM_MISALIGN_TRAP_EN -- when defined, a request whose byte
//            address is not word aligned is dropped (no stall, no RAM access),
//            MEM/WB takes a bubble and misalignO pulses for one cycle.
//            When undefined, misalignO stays 0 and the low address bits are
//            ignored.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_stage #(
  parameter int DEPTH_WORDS = 64,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jumpI,
  input  logic        branchI,
  input  logic        memReadI,
  input  logic        memWriteI,
  input  logic        memtoRegI,
  input  logic        regWriteI,
  input  logic [31:0] siguienteInstruccionI,
  input  logic        zfI,
  input  logic [31:0] aluResultI,
  input  logic [31:0] readData2I,
  input  logic [4:0]  writeRegistrerI,
  output logic        stallO,
  output logic        pcSrcO,
  output logic [31:0] targetO,
  output logic        regWriteO,
  output logic        memtoRegO,
  output logic [31:0] readDataO,
  output logic [31:0] aluResultO,
  output logic [4:0]  writeRegistrerO,
  output logic        validO,
  output logic        misalignO
);

  localparam int       ADDR_W   = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_to_reg_q, mem_to_reg_d;
  logic [31:0] read_data_q, read_data_d;
  logic [31:0] alu_result_q, alu_result_d;
  logic [4:0]  write_reg_q, write_reg_d;
  logic        valid_q, valid_d;
  logic        misalign_q, misalign_d;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [ADDR_W-1:0] idx;
  logic              req;
  logic              misalign_req;
  logic              commit;
  logic              mem_we;

  // Upper address bits are dropped, so addresses wrap modulo the RAM size.
  assign idx = aluResultI[ADDR_W+1:2];
  assign req = memReadI | memWriteI;

`ifdef MEM_MISALIGN_TRAP_EN
  assign misalign_req = req & (aluResultI[1:0] != 2'b00);
`else
  assign misalign_req = 1'b0;
`endif

  // Stall covers the request cycle in IDLE plus LATENCY-1 cycles of WAIT.
  assign stallO  = ((state_q == ST_IDLE) && req && !misalign_req) || (state_q == ST_WAIT);
  assign pcSrcO  = ((branchI & zfI) | jumpI) & ~stallO;
  assign targetO = siguienteInstruccionI;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    reg_write_d  = 1'b0;   // bubble unless this edge commits
    mem_to_reg_d = 1'b0;
    valid_d      = 1'b0;
    alu_result_d = alu_result_q;
    write_reg_d  = write_reg_q;
    read_data_d  = read_data_q;
    misalign_d   = 1'b0;
    commit       = 1'b0;
    mem_we       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (misalign_req) begin
          misalign_d = 1'b1;
        end else if (req) begin
          cnt_d   = CNT_INIT;
          state_d = (LATENCY == 1) ? ST_DONE : ST_WAIT;
        end else begin
          commit = 1'b1;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        commit  = 1'b1;
        state_d = ST_IDLE;
        if (memWriteI) begin
          mem_we = 1'b1;
          // Simultaneous read and write: the store wins, load data is zero.
          if (memReadI) begin
            read_data_d = 32'd0;
          end
        end else if (memReadI) begin
          read_data_d = mem[idx];
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (commit) begin
      reg_write_d  = regWriteI;
      mem_to_reg_d = memtoRegI;
      alu_result_d = aluResultI;
      write_reg_d  = writeRegistrerI;
      valid_d      = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      read_data_q  <= 32'd0;
      alu_result_q <= 32'd0;
      write_reg_q  <= 5'd0;
      valid_q      <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      write_reg_q  <= write_reg_d;
      valid_q      <= valid_d;
      misalign_q   <= misalign_d;
    end
  end

  // RAM is not reset; a reset mid-access forces IDLE so no write can occur.
  always_ff @(posedge clk) begin
    if (mem_we && !rst) begin
      mem[idx] <= readData2I;
    end
  end

  assign regWriteO       = reg_write_q;
  assign memtoRegO       = mem_to_reg_q;
  assign readDataO       = read_data_q;
  assign aluResultO      = alu_result_q;
  assign writeRegistrerO = write_reg_q;
  assign validO          = valid_q;
  assign misalignO       = misalign_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_access_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_access_stage
// Purpose  : Self-checking bench for mem_access_stage (DEPTH_WORDS=64,
//            LATENCY=2). Expected MEM/WB contents are queued when an
//            instruction is presented and popped whenever validO is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        jumpI, branchI, memReadI, memWriteI, memtoRegI, regWriteI, zfI;
  logic [31:0] siguienteInstruccionI, aluResultI, readData2I;
  logic [4:0]  writeRegistrerI;
  logic        stallO, pcSrcO, regWriteO, memtoRegO, validO, misalignO;
  logic [31:0] targetO, readDataO, aluResultO;
  logic [4:0]  writeRegistrerO;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        rw;
    logic        m2r;
    logic [31:0] alu;
    logic [4:0]  wr;
    logic [31:0] rd;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] last_rd;

  mem_access_stage #(.DEPTH_WORDS(64), .LATENCY(2)) dut (
    .clk(clk), .rst(rst),
    .jumpI(jumpI), .branchI(branchI), .memReadI(memReadI), .memWriteI(memWriteI),
    .memtoRegI(memtoRegI), .regWriteI(regWriteI),
    .siguienteInstruccionI(siguienteInstruccionI), .zfI(zfI),
    .aluResultI(aluResultI), .readData2I(readData2I), .writeRegistrerI(writeRegistrerI),
    .stallO(stallO), .pcSrcO(pcSrcO), .targetO(targetO),
    .regWriteO(regWriteO), .memtoRegO(memtoRegO), .readDataO(readDataO),
    .aluResultO(aluResultO), .writeRegistrerO(writeRegistrerO),
    .validO(validO), .misalignO(misalignO)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_nop();
    jumpI = 0; branchI = 0; memReadI = 0; memWriteI = 0; memtoRegI = 0;
    regWriteI = 0; zfI = 0; siguienteInstruccionI = 0; aluResultI = 0;
    readData2I = 0; writeRegistrerI = 0;
  endtask

  // Advance one clock; any valid MEM/WB output is matched against the queue.
  task automatic step();
    exp_t e;
    @(posedge clk);
    #1;
    if (validO === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_valid", 32'(validO), 32'd0);
      end else begin
        e = sb.pop_front();
        chk("wb_regwrite", 32'(regWriteO), 32'(e.rw));
        chk("wb_memtoreg", 32'(memtoRegO), 32'(e.m2r));
        chk("wb_alu", aluResultO, e.alu);
        chk("wb_wreg", 32'(writeRegistrerO), 32'(e.wr));
        chk("wb_rdata", readDataO, e.rd);
      end
    end
  endtask

  // Present one instruction, count stall cycles, then take the commit edge.
  task automatic issue(input logic rd_en, input logic wr_en, input logic rw,
                       input logic m2r, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] wreg,
                       input logic [31:0] load_val, input int exp_stall);
    exp_t e;
    int   n;
    memReadI = rd_en; memWriteI = wr_en; regWriteI = rw; memtoRegI = m2r;
    aluResultI = addr; readData2I = wdata; writeRegistrerI = wreg;
    if (rd_en && wr_en)  last_rd = 32'd0;
    else if (rd_en)      last_rd = load_val;
    e.rw = rw; e.m2r = m2r; e.alu = addr; e.wr = wreg; e.rd = last_rd;
    sb.push_back(e);
    #1;
    n = 0;
    while (stallO === 1'b1 && n < 20) begin
      if (jumpI) chk("pcsrc_in_stall", 32'(pcSrcO), 32'd0);
      n++;
      step();
    end
    chk("stall_cycles", 32'(n), 32'(exp_stall));
    if (jumpI) chk("pcsrc_at_done", 32'(pcSrcO), 32'd1);
    step();
    drive_nop();
  endtask

  initial begin
    drive_nop();
    last_rd = 32'd0;
    rst = 1'b1;
    step();
    step();
    // Reset state
    chk("rst_valid", 32'(validO), 32'd0);
    chk("rst_regwrite", 32'(regWriteO), 32'd0);
    chk("rst_alu", aluResultO, 32'd0);
    chk("rst_rdata", readDataO, 32'd0);
    chk("rst_stall", 32'(stallO), 32'd0);
    chk("rst_misalign", 32'(misalignO), 32'd0);
    rst = 1'b0;

    // Pass-through with no memory request: one-cycle latency, no stall
    issue(0, 0, 1, 0, 32'h55, 32'h0, 5'd5, 32'h0, 0);

    // Store then load the same word
    issue(0, 1, 0, 0, 32'h08, 32'h12345678, 5'd0, 32'h0, 2);
    issue(1, 0, 1, 1, 32'h08, 32'h0, 5'd3, 32'h12345678, 2);

    // Reset during WAIT aborts the store
    issue(0, 1, 0, 0, 32'h10, 32'h11111111, 5'd0, 32'h0, 2);
    memWriteI = 1; aluResultI = 32'h10; readData2I = 32'hDEADBEEF;
    #1;
    chk("abort_stall_req", 32'(stallO), 32'd1);
    step();
    drive_nop();
    rst = 1'b1;
    #1;
    chk("abort_valid", 32'(validO), 32'd0);
    chk("abort_alu", aluResultO, 32'd0);
    chk("abort_rdata", readDataO, 32'd0);
    chk("abort_stall", 32'(stallO), 32'd0);
    rst = 1'b0;
    last_rd = 32'd0;
    issue(1, 0, 1, 1, 32'h10, 32'h0, 5'd7, 32'h11111111, 2);

    // Redirect logic
    branchI = 1; zfI = 1; siguienteInstruccionI = 32'h40;
    #1;
    chk("pcsrc_taken", 32'(pcSrcO), 32'd1);
    chk("target", targetO, 32'h40);
    zfI = 0;
    #1;
    chk("pcsrc_not_taken", 32'(pcSrcO), 32'd0);
    drive_nop();
    jumpI = 1;
    issue(1, 0, 1, 1, 32'h08, 32'h0, 5'd4, 32'h12345678, 2);

    // Address wrap at DEPTH_WORDS*4
    issue(0, 1, 0, 0, 32'h100, 32'hA5A5A5A5, 5'd0, 32'h0, 2);
    issue(1, 0, 1, 1, 32'h000, 32'h0, 5'd9, 32'hA5A5A5A5, 2);

    // Read and write together: store wins, load data 0
    issue(1, 1, 1, 1, 32'h20, 32'h00000077, 5'd2, 32'h0, 2);
    issue(1, 0, 1, 1, 32'h20, 32'h0, 5'd2, 32'h00000077, 2);

    // Unaligned access
    issue(0, 1, 0, 0, 32'h04, 32'hCAFE0001, 5'd0, 32'h0, 2);
`ifdef MEM_MISALIGN_TRAP_EN
    memReadI = 1; regWriteI = 1; memtoRegI = 1; aluResultI = 32'h06; writeRegistrerI = 5'd6;
    #1;
    chk("misalign_no_stall", 32'(stallO), 32'd0);
    step();
    drive_nop();
    chk("misalign_flag", 32'(misalignO), 32'd1);
    chk("misalign_regwrite", 32'(regWriteO), 32'd0);
    chk("misalign_valid", 32'(validO), 32'd0);
    issue(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0, 0);
    chk("misalign_pulse_end", 32'(misalignO), 32'd0);
`else
    issue(1, 0, 1, 1, 32'h06, 32'h0, 5'd6, 32'hCAFE0001, 2);
    chk("misalign_tied", 32'(misalignO), 32'd0);
`endif

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
